// File: rtl/multicycle_divider_if.sv
// multicycle_divider_if
//   Groups the divider's request and result signals so the control unit
//   (master) and the divider (slave) share a single bundle.
//   Request : start, is_signed, a (dividend), b (divisor)  master -> slave
//   Result  : busy, done, div_zero, lo (quotient), hi (remainder)
//                                                          slave -> master
interface multicycle_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, div_zero, lo, hi
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, div_zero, lo, hi
    );
endinterface

// File: rtl/multicycle_divider.sv
// multicycle_divider
//   Iterative radix-2 restoring divider serving DIV (signed) and DIVU
//   (unsigned). One quotient bit is resolved per clock, so an operation
//   takes a fixed WIDTH+2 edges from the accepting edge to done.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-high; aborts any operation in flight
//     bus   - multicycle_divider_if slave modport:
//             start/is_signed/a/b sampled only while idle;
//             busy high during CALC/FIN, done a one-cycle pulse;
//             lo = quotient, hi = remainder, div_zero flags b == 0;
//             results hold until the next operation completes.
module multicycle_divider #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DZ_QUOTIENT = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_divider_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;

    logic             a_neg, b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        done_d  = 1'b0;
        divz_d  = divz_q;

        a_neg   = bus.is_signed & bus.a[WIDTH-1];
        b_neg   = bus.is_signed & bus.b[WIDTH-1];

        // Shift {rem, quo} left by one; the extra top bit keeps the
        // (WIDTH+1)-bit trial subtract exact, its MSB acting as the sign.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CALC;
                    cnt_d   = CW'(WIDTH - 1);
                    rem_d   = '0;
                    quo_d   = a_neg ? -bus.a : bus.a;
                    dvs_d   = b_neg ? -bus.b : bus.b;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    dz_d    = (bus.b == '0);
                end
            end
            S_CALC: begin
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                // With a zero divisor every trial succeeds, so rem ends up
                // holding |a|; the remainder sign fix then restores a itself.
                lo_d    = dz_q ? DZ_QUOTIENT : (negq_q ? -quo_q : quo_q);
                hi_d    = negr_q ? -rem_q : rem_q;
                divz_d  = dz_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = divz_q;
    assign bus.lo       = lo_q;
    assign bus.hi       = hi_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// tb_multicycle_divider
//   Directed vectors for the 32-bit divider. The driver pushes each
//   expected result onto a scoreboard queue when it issues a request; an
//   independent monitor pops and compares whenever done pulses.
module tb_multicycle_divider;

    localparam int W       = 32;
    localparam int LATENCY = 34;

    typedef struct {
        string       tag;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    multicycle_divider_if #(.WIDTH(W)) bus ();

    multicycle_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is seen by the following rising edge.
    task automatic issue(input string tag, input bit sg, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] elo,
                         input logic [31:0] ehi, input bit edz);
        exp_t e;
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.a         = av;
        bus.b         = bv;
        e.tag = tag; e.lo = elo; e.hi = ehi; e.dz = edz; e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = ~sg;
        bus.a         = $urandom;
        bus.b         = $urandom;
        check({tag, ".busy"}, {31'b0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1'b1;
        end
        check({tag, ".done_seen"}, {31'b0, got}, 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d want no pending op", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, ".lo"}, bus.lo, e.lo);
                    check({e.tag, ".hi"}, bus.hi, e.hi);
                    check({e.tag, ".div_zero"}, {31'b0, bus.div_zero}, {31'b0, e.dz});
                    check({e.tag, ".latency"}, 32'(cyc - e.cyc), 32'(LATENCY));
                    check({e.tag, ".busy_at_done"}, {31'b0, bus.busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.busy", {31'b0, bus.busy}, 32'd0);
        check("rst.done", {31'b0, bus.done}, 32'd0);
        check("rst.div_zero", {31'b0, bus.div_zero}, 32'd0);
        check("rst.lo", bus.lo, 32'd0);
        check("rst.hi", bus.hi, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        wait_done("u100_7");
        repeat (2) @(negedge clk);

        issue("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_done("s-7_2");
        repeat (2) @(negedge clk);

        issue("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_done("s7_-2");
        repeat (2) @(negedge clk);

        issue("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        wait_done("s_ovf");
        repeat (2) @(negedge clk);

        issue("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        wait_done("u_ovf");
        repeat (2) @(negedge clk);

        issue("u_dz", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        wait_done("u_dz");
        repeat (2) @(negedge clk);
        check("u_dz.hold_lo", bus.lo, 32'hFFFF_FFFF);
        check("u_dz.hold_dz", {31'b0, bus.div_zero}, 32'd1);

        issue("s_dz", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        wait_done("s_dz");
        repeat (2) @(negedge clk);

        issue("s_dz_neg", 1'b1, 32'hF000_0000, 32'd0, 32'hFFFF_FFFF, 32'hF000_0000, 1'b1);
        wait_done("s_dz_neg");
        repeat (2) @(negedge clk);

        issue("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        wait_done("u50_5");
        repeat (2) @(negedge clk);

        // Second start while busy must be ignored entirely.
        issue("ign", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ign");
        repeat (40) @(negedge clk);

        // Start in the done cycle is accepted with no idle gap.
        issue("b2b_a", 1'b1, 32'hFFFF_FF9C, 32'd9, 32'hFFFF_FFF5, 32'hFFFF_FFFF, 1'b0);
        wait_done("b2b_a");
        issue("b2b_b", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0);
        wait_done("b2b_b");
        repeat (2) @(negedge clk);

        // Reset ten cycles into CALC aborts without a done pulse.
        issue("abort", 1'b0, 32'd12345, 32'd3, 32'd4115, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort.busy", {31'b0, bus.busy}, 32'd0);
        check("abort.done", {31'b0, bus.done}, 32'd0);
        check("abort.lo", bus.lo, 32'd0);
        check("abort.hi", bus.hi, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        issue("post9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        wait_done("post9_3");
        repeat (5) @(negedge clk);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
